// File: rtl/ball_motion_ctrl.sv
// Ball motion sequencer for the VGA playfield.
// Serve, countdown and pause are handled by a small FSM.
// In RUN the ball moves SPEED pixels per axis on each frame_tick and is
// clamped and reflected at the four playfield edges.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for serve_req; frame ticks ignored
// COUNTDOWN | counting SERVE_FRAMES frame ticks before the ball moves
// RUN       | ball advances once per frame_tick
// PAUSED    | position frozen until the next pause_req
module ball_motion_ctrl #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int BALL_SIZE    = 4,
  parameter int INIT_X       = 128,
  parameter int INIT_Y       = 128,
  parameter int SPEED        = 2,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       serve_req,
  input  logic       pause_req,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [1:0] state,
  output logic       bounce_h,
  output logic       bounce_v,
  output logic [7:0] bounce_count
);

  // Edge comparisons are done 11 bits wide so neither subtraction nor
  // addition can wrap around.
  localparam logic [10:0] XMAX11 = 11'(H_ACTIVE - BALL_SIZE);
  localparam logic [10:0] YMAX11 = 11'(V_ACTIVE - BALL_SIZE);
  localparam logic [10:0] SPD11  = 11'(SPEED);
  localparam logic [9:0]  INIT_X10 = 10'(INIT_X);
  localparam logic [9:0]  INIT_Y10 = 10'(INIT_Y);
  localparam logic [7:0]  SERVE8   = 8'(SERVE_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_COUNTDOWN = 2'd1,
    S_RUN       = 2'd2,
    S_PAUSED    = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_load;
  logic        w_move;
  logic        w_fc_inc;
  logic        w_fc_done;
  logic [7:0]  w_fc_next;

  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic        r_dir_x;   // 1 = moving left
  logic        r_dir_y;   // 1 = moving down
  logic        r_bh;
  logic        r_bv;
  logic [7:0]  r_cnt;
  logic [7:0]  r_fcnt;

  logic [10:0] w_x_ext;
  logic [10:0] w_y_ext;
  logic [9:0]  w_x_nxt;
  logic [9:0]  w_y_nxt;
  logic        w_hit_x;
  logic        w_hit_y;
  logic [8:0]  w_cnt_sum;
  logic [7:0]  w_cnt_nxt;

  assign w_fc_next = r_fcnt + 8'd1;
  assign w_fc_done = (w_fc_next == SERVE8);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and datapath control; pause_req takes priority over a
  // coincident frame_tick in RUN so that frame produces no movement.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_move      = 1'b0;
    w_fc_inc    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (serve_req) begin
          w_state_nxt = S_COUNTDOWN;
          w_load      = 1'b1;
        end
      end
      S_COUNTDOWN: begin
        if (frame_tick) begin
          w_fc_inc = 1'b1;
          if (w_fc_done) w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (pause_req)       w_state_nxt = S_PAUSED;
        else if (frame_tick) w_move      = 1'b1;
      end
      S_PAUSED: begin
        if (pause_req) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_x_ext = {1'b0, r_x};
  assign w_y_ext = {1'b0, r_y};

  // X axis step: move by SPEED, clamp at 0 / XMAX and flag a wall hit.
  always_comb begin
    w_x_nxt = r_x;
    w_hit_x = 1'b0;
    if (r_dir_x) begin
      if (w_x_ext <= SPD11) begin
        w_x_nxt = '0;
        w_hit_x = 1'b1;
      end else begin
        w_x_nxt = 10'(w_x_ext - SPD11);
      end
    end else begin
      if (w_x_ext >= XMAX11 - SPD11) begin
        w_x_nxt = XMAX11[9:0];
        w_hit_x = 1'b1;
      end else begin
        w_x_nxt = 10'(w_x_ext + SPD11);
      end
    end
  end

  // Y axis step: down is increasing Y, clamp at 0 / YMAX.
  always_comb begin
    w_y_nxt = r_y;
    w_hit_y = 1'b0;
    if (!r_dir_y) begin
      if (w_y_ext <= SPD11) begin
        w_y_nxt = '0;
        w_hit_y = 1'b1;
      end else begin
        w_y_nxt = 10'(w_y_ext - SPD11);
      end
    end else begin
      if (w_y_ext >= YMAX11 - SPD11) begin
        w_y_nxt = YMAX11[9:0];
        w_hit_y = 1'b1;
      end else begin
        w_y_nxt = 10'(w_y_ext + SPD11);
      end
    end
  end

  // Single adder of at most +2 per frame, saturating at 255.
  always_comb begin
    w_cnt_sum = {1'b0, r_cnt} + 9'(w_hit_x) + 9'(w_hit_y);
    w_cnt_nxt = (w_cnt_sum > 9'd255) ? 8'hFF : w_cnt_sum[7:0];
  end

  // Position, direction, pulse, bounce count and frame counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x     <= INIT_X10;
      r_y     <= INIT_Y10;
      r_dir_x <= 1'b1;
      r_dir_y <= 1'b1;
      r_bh    <= 1'b0;
      r_bv    <= 1'b0;
      r_cnt   <= '0;
      r_fcnt  <= '0;
    end else begin
      r_bh <= 1'b0;
      r_bv <= 1'b0;
      if (w_load) begin
        r_x     <= INIT_X10;
        r_y     <= INIT_Y10;
        r_dir_x <= 1'b1;
        r_dir_y <= 1'b1;
        r_cnt   <= '0;
        r_fcnt  <= '0;
      end else begin
        if (w_fc_inc) r_fcnt <= w_fc_next;
        if (w_move) begin
          r_x     <= w_x_nxt;
          r_y     <= w_y_nxt;
          r_dir_x <= r_dir_x ^ w_hit_x;
          r_dir_y <= r_dir_y ^ w_hit_y;
          r_bh    <= w_hit_x;
          r_bv    <= w_hit_y;
          r_cnt   <= w_cnt_nxt;
        end
      end
    end
  end

  assign ball_x       = r_x;
  assign ball_y       = r_y;
  assign state        = r_state;
  assign bounce_h     = r_bh;
  assign bounce_v     = r_bv;
  assign bounce_count = r_cnt;

endmodule
